// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file.
// Groups the decode-side read ports, the two write-back lanes and the
// bulk-clear handshake. The master modport is the pipeline side; the slave
// modport is the register file itself.
//   rd_addr  : NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data  : NRD packed read data,     port k at [k*XLEN +: XLEN]
//   we0/wa0/wd0 : write lane 0
//   we1/wa1/wd1 : write lane 1 (wins on address collision)
//   clr_req  : bulk-clear request
//   clr_busy : clear sweep in progress
//   clr_done : one-cycle pulse at sweep completion
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, clr_req,
    input  rd_data, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, clr_req,
    output rd_data, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the RV32I pipeline.
// NRD combinational read ports, two write lanes (lane 1 has priority),
// optional same-cycle write-to-read bypass, and a bulk-clear sequencer that
// sweeps registers 1..NREG-1 back to their reset values.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : regfile_mp_if slave modport (read ports, write lanes, clear handshake)
// Register 0 reads as zero and ignores writes. Register SP_IDX resets and
// clears to SP_INIT, all others to zero.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = $clog2(NREG),
  parameter int unsigned NRD     = 2,
  parameter int unsigned SP_IDX  = 2,
  parameter int unsigned SP_INIT = 1024,
  parameter int unsigned BYPASS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] regs [NREG];
  logic            clr_busy;
  logic            clr_done;
  logic [AW-1:0]   ra [NRD];
  logic [XLEN-1:0] rv [NRD];
  logic [NRD*XLEN-1:0] rd_data_c;

  function automatic logic [XLEN-1:0] init_val(input int unsigned i);
    return (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
  endfunction

  // Clear sequencer: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Clear sequencer: next state and status outputs
  always_comb begin
    state_nx = state;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    unique case (state)
      IDLE:  if (bus.clr_req) state_nx = SWEEP;
      SWEEP: begin
        clr_busy = 1'b1;
        if (idx == AW'(NREG - 1)) state_nx = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Array, sweep index and write lanes. Lane 1 is applied after lane 0 so it
  // wins a same-address collision. Register 0 is never written, so it holds
  // its reset zero forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[AW'(i)] <= init_val(i);
      idx <= AW'(1);
    end else begin
      if (state == IDLE && bus.clr_req) begin
        idx <= AW'(1);
      end else if (state == SWEEP) begin
        regs[idx] <= init_val(32'(idx));
        idx       <= idx + AW'(1);
      end
      if (!clr_busy) begin
        if (bus.we0 && bus.wa0 != '0) regs[bus.wa0] <= bus.wd0;
        if (bus.we1 && bus.wa1 != '0) regs[bus.wa1] <= bus.wd1;
      end
    end
  end

  // Combinational reads. Forwarding is suppressed during a sweep because the
  // write lanes are being discarded then; address 0 is forced to zero last so
  // it overrides any forwarded value.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra[k] = bus.rd_addr[k*AW +: AW];
      rv[k] = regs[ra[k]];
      if (BYPASS != 0 && !clr_busy) begin
        if (bus.we0 && bus.wa0 == ra[k]) rv[k] = bus.wd0;
        if (bus.we1 && bus.wa1 == ra[k]) rv[k] = bus.wd1;
      end
      if (ra[k] == '0) rv[k] = '0;
      rd_data_c[k*XLEN +: XLEN] = rv[k];
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp.
// Instance A: NREG=32, NRD=2, BYPASS=1. Instance B: NREG=16, NRD=4, BYPASS=0.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) bus_a ();
  regfile_mp_if #(.XLEN(32), .AW(4), .NRD(4)) bus_b ();

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  regfile_mp #(.XLEN(32), .NREG(16), .NRD(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input bit we0, input int wa0, input logic [31:0] wd0,
                              input bit we1, input int wa1, input logic [31:0] wd1,
                              input int ra0, input int ra1,
                              input logic [31:0] exp0, input logic [31:0] exp1);
    vec_t v;
    v.we0 = we0; v.wa0 = 5'(wa0); v.wd0 = wd0;
    v.we1 = we1; v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
    v.exp0 = exp0; v.exp1 = exp1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one clear sweep on instance A and reports what it observed.
  // A write to reg 9 is attempted mid-sweep (after reg 9 is already cleared),
  // clr_req is re-pulsed while busy and again during the done cycle.
  task automatic sweep_a(output int busy_n, output int done_n,
                         output int last_busy, output int first_done);
    busy_n = 0; done_n = 0; last_busy = -1; first_done = -1;
    @(negedge clk); bus_a.clr_req = 1'b1;
    @(negedge clk); bus_a.clr_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus_a.clr_busy) begin busy_n++; last_busy = c; end
      if (bus_a.clr_done) begin done_n++; if (first_done < 0) first_done = c; end
      bus_a.clr_req = bus_a.clr_done || (c == 25);
      if (c == 20) begin
        bus_a.we0 = 1'b1; bus_a.wa0 = 5'd9; bus_a.wd0 = 32'hBAD0BAD0;
        bus_a.rd_addr = {5'd0, 5'd9};
        #1;
        check("sweep_no_bypass", bus_a.rd_data[31:0], 32'h0);
      end else begin
        bus_a.we0 = 1'b0;
      end
      @(negedge clk);
    end
    bus_a.clr_req = 1'b0;
    bus_a.we0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, dn, lb, fd;

    bus_a.rd_addr = '0; bus_a.we0 = 1'b0; bus_a.wa0 = '0; bus_a.wd0 = '0;
    bus_a.we1 = 1'b0; bus_a.wa1 = '0; bus_a.wd1 = '0; bus_a.clr_req = 1'b0;
    bus_b.rd_addr = '0; bus_b.we0 = 1'b0; bus_b.wa0 = '0; bus_b.wd0 = '0;
    bus_b.we1 = 1'b0; bus_b.wa1 = '0; bus_b.wd1 = '0; bus_b.clr_req = 1'b0;

    vecs[0]  = mk(0, 0, 0,             0, 0, 0,       0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0,             0, 0, 0,       2, 31, 1024, 0);
    vecs[2]  = mk(1, 5, 32'hDEADBEEF,  0, 0, 0,       5, 2, 32'hDEADBEEF, 1024);
    vecs[3]  = mk(0, 0, 0,             0, 0, 0,       5, 0, 32'hDEADBEEF, 0);
    vecs[4]  = mk(1, 0, 32'h1234,      0, 0, 0,       0, 5, 0, 32'hDEADBEEF);
    vecs[5]  = mk(0, 0, 0,             0, 0, 0,       0, 1, 0, 0);
    vecs[6]  = mk(1, 7, 32'h11,        1, 7, 32'h22,  7, 7, 32'h22, 32'h22);
    vecs[7]  = mk(0, 0, 0,             0, 0, 0,       7, 5, 32'h22, 32'hDEADBEEF);
    vecs[8]  = mk(1, 3, 32'hA5A5,      1, 4, 32'h5A5A, 3, 4, 32'hA5A5, 32'h5A5A);
    vecs[9]  = mk(0, 0, 0,             0, 0, 0,       3, 4, 32'hA5A5, 32'h5A5A);
    vecs[10] = mk(1, 3, 32'h33,        0, 3, 32'h99,  3, 4, 32'h33, 32'h5A5A);
    vecs[11] = mk(0, 0, 0,             0, 0, 0,       3, 4, 32'h33, 32'h5A5A);
    vecs[12] = mk(0, 0, 0,             1, 2, 32'h77,  2, 1, 32'h77, 0);
    vecs[13] = mk(0, 0, 0,             0, 0, 0,       2, 0, 32'h77, 0);

    // Reset state seen while rst is still asserted
    repeat (2) @(negedge clk);
    bus_a.rd_addr = {5'd31, 5'd2};
    #1;
    check("rst_rd2",   bus_a.rd_data[31:0],  32'd1024);
    check("rst_rd31",  bus_a.rd_data[63:32], 32'd0);
    check("rst_busy",  32'(bus_a.clr_busy), 0);
    check("rst_done",  32'(bus_a.clr_done), 0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven write/read vectors on instance A
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus_a.we0 = vecs[i].we0; bus_a.wa0 = vecs[i].wa0; bus_a.wd0 = vecs[i].wd0;
      bus_a.we1 = vecs[i].we1; bus_a.wa1 = vecs[i].wa1; bus_a.wd1 = vecs[i].wd1;
      bus_a.rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_rd0", i), bus_a.rd_data[31:0],  vecs[i].exp0);
      check($sformatf("vec%0d_rd1", i), bus_a.rd_data[63:32], vecs[i].exp1);
      check($sformatf("vec%0d_busy", i), 32'(bus_a.clr_busy), 0);
    end
    @(negedge clk);
    bus_a.we0 = 1'b0; bus_a.we1 = 1'b0;

    // Load regs 1..31 with their index, then sweep
    for (int r = 1; r < 32; r++) begin
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'(r); bus_a.wd0 = 32'(r);
      @(negedge clk);
    end
    bus_a.we0 = 1'b0;
    bus_a.rd_addr = {5'd31, 5'd9};
    #1;
    check("load_rd9",  bus_a.rd_data[31:0],  32'd9);
    check("load_rd31", bus_a.rd_data[63:32], 32'd31);

    sweep_a(bn, dn, lb, fd);
    check("sweep_busy_cycles", 32'(bn), 32'd31);
    check("sweep_done_pulses", 32'(dn), 32'd1);
    check("sweep_done_follows", 32'(fd), 32'(lb + 1));

    for (int r = 0; r < 32; r += 2) begin
      bus_a.rd_addr = {5'(r + 1), 5'(r)};
      #1;
      check($sformatf("clr_rd%0d", r),     bus_a.rd_data[31:0],  (r == 2) ? 32'd1024 : 32'd0);
      check($sformatf("clr_rd%0d", r + 1), bus_a.rd_data[63:32], 32'd0);
    end

    // Reset in the middle of a sweep
    @(negedge clk);
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd20; bus_a.wd0 = 32'h2020;
    @(negedge clk);
    bus_a.we0 = 1'b0;
    bus_a.clr_req = 1'b1;
    @(negedge clk);
    bus_a.clr_req = 1'b0;
    repeat (10) @(negedge clk);
    bus_a.rd_addr = {5'd2, 5'd20};
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus_a.clr_busy), 0);
    check("midrst_done", 32'(bus_a.clr_done), 0);
    check("midrst_rd20", bus_a.rd_data[31:0],  32'd0);
    check("midrst_rd2",  bus_a.rd_data[63:32], 32'd1024);
    bus_b.rd_addr = {4'd15, 4'd2, 4'd1, 4'd0};
    #1;
    check("b_rst_rd0",  bus_b.rd_data[31:0],   32'd0);
    check("b_rst_rd1",  bus_b.rd_data[63:32],  32'd0);
    check("b_rst_rd2",  bus_b.rd_data[95:64],  32'd1024);
    check("b_rst_rd15", bus_b.rd_data[127:96], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dn = 0; bn = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus_a.clr_done) dn++;
      if (bus_a.clr_busy) bn++;
      @(negedge clk);
    end
    check("postrst_no_done", 32'(dn), 0);
    check("postrst_no_busy", 32'(bn), 0);

    sweep_a(bn, dn, lb, fd);
    check("resweep_busy_cycles", 32'(bn), 32'd31);
    check("resweep_done_pulses", 32'(dn), 32'd1);

    // Instance B: four read ports, no bypass, 16 registers
    @(negedge clk);
    bus_b.we0 = 1'b1; bus_b.wa0 = 4'd3; bus_b.wd0 = 32'h3333;
    bus_b.we1 = 1'b1; bus_b.wa1 = 4'd6; bus_b.wd1 = 32'h6666;
    bus_b.rd_addr = {4'd0, 4'd0, 4'd6, 4'd3};
    #1;
    check("b_nobyp_rd3", bus_b.rd_data[31:0],  32'd0);
    check("b_nobyp_rd6", bus_b.rd_data[63:32], 32'd0);
    @(negedge clk);
    bus_b.wa0 = 4'd9;  bus_b.wd0 = 32'h9999;
    bus_b.wa1 = 4'd15; bus_b.wd1 = 32'hF0F0;
    @(negedge clk);
    bus_b.wa0 = 4'd7; bus_b.wd0 = 32'h70;
    bus_b.we1 = 1'b0;
    @(negedge clk);
    bus_b.wa0 = 4'd7; bus_b.wd0 = 32'h11;
    bus_b.we1 = 1'b1; bus_b.wa1 = 4'd7; bus_b.wd1 = 32'h22;
    bus_b.rd_addr = {4'd0, 4'd0, 4'd0, 4'd7};
    #1;
    check("b_collide_old", bus_b.rd_data[31:0], 32'h70);
    @(negedge clk);
    bus_b.we0 = 1'b0; bus_b.we1 = 1'b0;
    bus_b.rd_addr = {4'd15, 4'd9, 4'd6, 4'd3};
    #1;
    check("b_rd3",  bus_b.rd_data[31:0],   32'h3333);
    check("b_rd6",  bus_b.rd_data[63:32],  32'h6666);
    check("b_rd9",  bus_b.rd_data[95:64],  32'h9999);
    check("b_rd15", bus_b.rd_data[127:96], 32'hF0F0);
    bus_b.rd_addr = {4'd1, 4'd2, 4'd0, 4'd7};
    #1;
    check("b_collide_new", bus_b.rd_data[31:0],   32'h22);
    check("b_rd0",         bus_b.rd_data[63:32],  32'd0);
    check("b_rd2",         bus_b.rd_data[95:64],  32'd1024);
    check("b_rd1",         bus_b.rd_data[127:96], 32'd0);

    @(negedge clk);
    bus_b.clr_req = 1'b1;
    @(negedge clk);
    bus_b.clr_req = 1'b0;
    bn = 0; dn = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (bus_b.clr_busy) bn++;
      if (bus_b.clr_done) dn++;
      @(negedge clk);
    end
    check("b_sweep_busy_cycles", 32'(bn), 32'd15);
    check("b_sweep_done_pulses", 32'(dn), 32'd1);
    bus_b.rd_addr = {4'd15, 4'd9, 4'd2, 4'd3};
    #1;
    check("b_clr_rd3",  bus_b.rd_data[31:0],   32'd0);
    check("b_clr_rd2",  bus_b.rd_data[63:32],  32'd1024);
    check("b_clr_rd9",  bus_b.rd_data[95:64],  32'd0);
    check("b_clr_rd15", bus_b.rd_data[127:96], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RV32I pipeline core. It provides NRD combinational read ports and two write ports (WB lane 0, WB lane 1) with fixed priority. Optional same-cycle write-to-read bypass is included. A hardware bulk-clear sequencer returns the architectural state to reset values without asserting the global reset. The block sits between decode (reads) and write-back (writes).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=4)
AW, $clog2(NREG), register address width
NRD, 2, number of read ports (1..4)
SP_IDX, 2, index of stack-pointer register
SP_INIT, 1024, reset/clear value of register SP_IDX
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
we0  in  1  write enable, lane 0
wa0  in  AW  write address, lane 0
wd0  in  XLEN  write data, lane 0
we1  in  1  write enable, lane 1 (higher priority)
wa1  in  AW  write address, lane 1
wd1  in  XLEN  write data, lane 1
clr_req  in  1  bulk-clear request, sampled in IDLE only
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse when sweep completes

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asynchronous): all registers 0 except reg[SP_IDX]=SP_INIT. FSM=IDLE, sweep index=1, clr_busy=0, clr_done=0. rd_data reflects the reset array immediately.
- Register 0 is hardwired zero: writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- Writes commit on posedge clk when weN=1 and clr_busy=0. Both lanes to different addresses: both commit. Same address: lane 1 value commits, lane 0 is discarded.
- Reads are combinational, with zero latency from rd_addr.
- BYPASS=1 and clr_busy=0: if rd_addr matches an enabled, nonzero write address this cycle, rd_data returns the matching wd (lane 1 over lane 0). Otherwise rd_data returns array contents. BYPASS=0 never forwards.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 -> SWEEP next cycle, index=1.
  - SWEEP: clr_busy=1. Each cycle writes reg[index] <= (index==SP_IDX ? SP_INIT : 0) and increments index. When index==NREG-1 is written -> DONE.
  - DONE: clr_busy=0, clr_done=1 for exactly one cycle -> IDLE.
- A sweep lasts NREG-1 cycles with clr_busy high. The clr_done pulse follows on the next cycle.
- While clr_busy=1: we0/we1 are ignored (writes lost, no stall is generated here; the pipeline must hold WB). clr_req is ignored. Reads return array contents with no bypass.
- clr_req is ignored in DONE. A new request is accepted only from IDLE.
- Reset asserted mid-sweep: immediate full reset, FSM=IDLE, no clr_done pulse.
- Width rule: addresses >= NREG cannot occur (NREG is a power of two). No truncation or extension of data is performed.

Test Plan:
- Reset release: reads of reg 0,1,2,31 -> 0,0,1024,0. clr_busy=0, clr_done=0.
- we0=1, wa0=5, wd0=0xDEADBEEF; next cycle read 5 -> 0xDEADBEEF. Write wa0=0, wd0=0x1234; read 0 -> 0.
- we0=1 and we1=1 both to address 7 with wd0=0x11, wd1=0x22 -> reg7=0x22. Same cycle with BYPASS=1, rd_addr=7 -> 0x22. With BYPASS=0 -> previous value.
- Load regs 1..31 with their index, pulse clr_req -> clr_busy high for exactly 31 cycles, then clr_done high for 1 cycle. All regs 0 except reg2=1024. we0 to reg 9 during the sweep is lost (reg9=0 after).
- Start sweep, assert rst low at sweep cycle 10 -> clr_busy drops asynchronously, no clr_done pulse, array fully reset. clr_req after release starts a fresh sweep.
- NRD=4, NREG=16: four simultaneous reads of distinct written registers return the correct values. Sweep length is 15 cycles.
